// File: rtl/chnl_acum_ctrl.sv
// Sequencer for the channel-accumulation datapath: accepts conv column beats,
// tracks column/channel/kernel position and replays them LAT cycles later as accumulator strobes.
module chnl_acum_ctrl #(
    parameter int WID  = 56,
    parameter int CHNL = 64,
    parameter int KNUM = 64,
    parameter int LAT  = 4,
    parameter int CW   = $clog2(WID),
    parameter int KW   = $clog2(KNUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          col_valid_i,
    output logic          col_ready_o,
    input  logic          out_afull_i,
    output logic          acc_en_o,
    output logic          acc_first_o,
    output logic          out_valid_o,
    output logic [CW-1:0] out_col_o,
    output logic [KW-1:0] kern_idx_o
);

    localparam int CHW = (CHNL > 1) ? $clog2(CHNL) : 1;
    localparam int DW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic          vld;
        logic          first;
        logic          last;
        logic [CW-1:0] col;
        logic [KW-1:0] kern;
    } beat_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_cnt_q, col_cnt_d;
    logic [CHW-1:0]   chnl_cnt_q, chnl_cnt_d;
    logic [KW-1:0]    kern_cnt_q, kern_cnt_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    beat_t            pipe_q [LAT];
    beat_t            pipe_d [LAT];

    logic             col_last;
    logic             chnl_last;
    logic             kern_last;
    logic             ready;
    logic             accept;
    beat_t            beat_in;

    always_comb begin
        col_last  = (col_cnt_q == CW'(WID - 1));
        chnl_last = (chnl_cnt_q == CHW'(CHNL - 1));
        kern_last = (kern_cnt_q == KW'(KNUM - 1));
        // Backpressure only gates last-channel beats: those are the ones that produce output.
        ready     = (state_q == S_RUN) && !(chnl_last && out_afull_i);
        accept    = col_valid_i && ready;

        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        chnl_cnt_d  = chnl_cnt_q;
        kern_cnt_d  = kern_cnt_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    col_cnt_d  = '0;
                    chnl_cnt_d = '0;
                    kern_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    col_cnt_d = col_last ? '0 : col_cnt_q + CW'(1);
                    if (col_last) begin
                        chnl_cnt_d = chnl_last ? '0 : chnl_cnt_q + CHW'(1);
                        if (chnl_last) begin
                            kern_cnt_d = kern_last ? '0 : kern_cnt_q + KW'(1);
                        end
                    end
                    if (col_last && chnl_last && kern_last) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DW'(LAT);
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q - DW'(1);
                if (drain_cnt_q == DW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);

        // Bubbles enter the pipe as all-zero beats so flags are gated for free.
        beat_in       = '0;
        beat_in.vld   = accept;
        beat_in.first = accept && (chnl_cnt_q == '0);
        beat_in.last  = accept && chnl_last;
        beat_in.col   = accept ? col_cnt_q : '0;
        beat_in.kern  = accept ? kern_cnt_q : '0;

        pipe_d[0] = beat_in;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            chnl_cnt_q  <= '0;
            kern_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            chnl_cnt_q  <= chnl_cnt_d;
            kern_cnt_q  <= kern_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign col_ready_o = ready;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign acc_en_o    = pipe_q[LAT-1].vld;
    assign acc_first_o = pipe_q[LAT-1].first;
    assign out_valid_o = pipe_q[LAT-1].last;
    assign out_col_o   = pipe_q[LAT-1].col;
    assign kern_idx_o  = pipe_q[LAT-1].kern;

endmodule

// File: tb/tb_chnl_acum_ctrl.sv
// Bench for chnl_acum_ctrl: a small 4x3x2 instance scored against a cycle-stamped
// expected-beat queue, plus a 1x1x1 LAT=1 instance for the degenerate case.
`timescale 1ns/1ps
module tb_chnl_acum_ctrl;

    localparam int WID   = 4;
    localparam int CHNL  = 3;
    localparam int KNUM  = 2;
    localparam int LAT   = 4;
    localparam int CW    = 2;
    localparam int KW    = 1;
    localparam int NBEAT = WID * CHNL * KNUM;
    localparam int W     = 32 + 2 + CW + KW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          a_start, a_busy, a_done, a_valid, a_ready, a_afull;
    logic          a_acc_en, a_first, a_ovld;
    logic [CW-1:0] a_col;
    logic [KW-1:0] a_kern;

    logic          b_start, b_busy, b_done, b_valid, b_ready, b_afull;
    logic          b_acc_en, b_first, b_ovld;
    logic [0:0]    b_col;
    logic [0:0]    b_kern;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            n_emit = 0;
    int            n_first = 0;
    int            n_last = 0;
    int            first_acc = 0;
    int            last_acc = 0;
    int            m_col = 0;
    int            m_chnl = 0;
    int            m_kern = 0;
    bit            mon_en = 1'b0;
    logic [W-1:0]  exp_q[$];

    chnl_acum_ctrl #(.WID(WID), .CHNL(CHNL), .KNUM(KNUM), .LAT(LAT), .CW(CW), .KW(KW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .col_valid_i(a_valid), .col_ready_o(a_ready), .out_afull_i(a_afull),
        .acc_en_o(a_acc_en), .acc_first_o(a_first), .out_valid_o(a_ovld),
        .out_col_o(a_col), .kern_idx_o(a_kern)
    );

    chnl_acum_ctrl #(.WID(1), .CHNL(1), .KNUM(1), .LAT(1), .CW(1), .KW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .col_valid_i(b_valid), .col_ready_o(b_ready), .out_afull_i(b_afull),
        .acc_en_o(b_acc_en), .acc_first_o(b_first), .out_valid_o(b_ovld),
        .out_col_o(b_col), .kern_idx_o(b_kern)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (mon_en) begin
            if (a_acc_en === 1'b1) begin
                n_emit++;
                if (a_first) n_first++;
                if (a_ovld) n_last++;
                got = {32'(cyc), a_first, a_ovld, a_col, a_kern};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got %h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL beat cyc/first/last/col/kern: got %h required %h", got, e);
                    end
                end
            end else begin
                total++;
                if ({a_first, a_ovld} !== 2'b00) begin
                    bad++;
                    $display("FAIL idle_flags: got %b required 00", {a_first, a_ovld});
                end
            end
            if (a_valid === 1'b1 && a_ready === 1'b1) begin
                exp_q.push_back({32'(cyc + LAT), m_chnl == 0, m_chnl == CHNL - 1,
                                 CW'(m_col), KW'(m_kern)});
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                m_col++;
                if (m_col == WID) begin
                    m_col = 0;
                    m_chnl++;
                    if (m_chnl == CHNL) begin
                        m_chnl = 0;
                        m_kern++;
                        if (m_kern == KNUM) m_kern = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_model();
        exp_q.delete();
        n_acc = 0; n_emit = 0; n_first = 0; n_last = 0;
        m_col = 0; m_chnl = 0; m_kern = 0;
    endtask

    task automatic drive_pass(input bit toggle, input bit poke_run, input bit poke_drain,
                              input bit do_start);
        bit poked;
        poked = 1'b0;
        if (do_start) begin
            @(posedge clk); #1;
            a_start = 1'b1;
        end
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            if (n_acc >= NBEAT) break;
            a_valid = toggle ? (k % 2 == 0) : 1'b1;
            if (poke_run && !poked && n_acc == 5) begin
                a_start = 1'b1;
                poked = 1'b1;
            end
        end
        a_valid = 1'b0;
        if (poke_drain) begin
            a_start = 1'b1;
            @(posedge clk); #1;
            a_start = 1'b0;
        end
    endtask

    task automatic wait_done(output int dcyc, output bit ok);
        ok = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                dcyc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({a_busy, a_done, a_ready, a_acc_en, a_first, a_ovld} !== 6'b0) begin
            bad++;
            $display("FAIL reset_status_a: got %b required 000000",
                     {a_busy, a_done, a_ready, a_acc_en, a_first, a_ovld});
        end
        total++;
        if ({a_col, a_kern} !== '0) begin
            bad++;
            $display("FAIL reset_data_a: got %h required 0", {a_col, a_kern});
        end
        total++;
        if ({b_busy, b_done, b_ready, b_acc_en, b_first, b_ovld, b_col, b_kern} !== 8'b0) begin
            bad++;
            $display("FAIL reset_b: got %b required 0",
                     {b_busy, b_done, b_ready, b_acc_en, b_first, b_ovld, b_col, b_kern});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_busy, a_ready} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got %b required 00", {a_busy, a_ready});
        end
    endtask

    task automatic check_pass_end(input string name);
        int dcyc;
        bit ok;
        total++;
        if (n_acc !== NBEAT) begin
            bad++;
            $display("FAIL %s_accepts: got %0d required %0d", name, n_acc, NBEAT);
        end
        wait_done(dcyc, ok);
        total++;
        if (!ok || dcyc !== last_acc + LAT + 1) begin
            bad++;
            $display("FAIL %s_done_cycle: got %0d required %0d", name, dcyc, last_acc + LAT + 1);
        end
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: got %b required 0", name, a_busy);
        end
        total++;
        if (exp_q.size() != 0 || n_emit != NBEAT) begin
            bad++;
            $display("FAIL %s_emits: got %0d left %0d required %0d left 0",
                     name, n_emit, exp_q.size(), NBEAT);
        end
    endtask

    task automatic test_full_rate();
        reset_model();
        drive_pass(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (last_acc - first_acc !== NBEAT - 1) begin
            bad++;
            $display("FAIL full_rate_span: got %0d required %0d", last_acc - first_acc, NBEAT - 1);
        end
        check_pass_end("full_rate");
        total++;
        if (n_first !== WID * KNUM || n_last !== WID * KNUM) begin
            bad++;
            $display("FAIL full_rate_flags: got first=%0d last=%0d required %0d each",
                     n_first, n_last, WID * KNUM);
        end
    endtask

    task automatic test_toggle();
        reset_model();
        drive_pass(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (last_acc - first_acc !== 2 * (NBEAT - 1)) begin
            bad++;
            $display("FAIL toggle_span: got %0d required %0d", last_acc - first_acc, 2 * (NBEAT - 1));
        end
        check_pass_end("toggle");
    endtask

    task automatic test_afull();
        int emit0;
        reset_model();
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (n_acc >= WID * (CHNL - 1)) break;
        end
        total++;
        if (n_acc !== WID * (CHNL - 1) || last_acc - first_acc !== WID * (CHNL - 1) - 1) begin
            bad++;
            $display("FAIL afull_pre_span: got n=%0d span=%0d required n=%0d span=%0d",
                     n_acc, last_acc - first_acc, WID * (CHNL - 1), WID * (CHNL - 1) - 1);
        end
        a_afull = 1'b1;
        emit0 = n_emit;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (a_ready !== 1'b0) begin
                bad++;
                $display("FAIL afull_ready_low[%0d]: got %b required 0", i, a_ready);
            end
        end
        @(posedge clk); #1;
        a_afull = 1'b0;
        total++;
        if (n_emit - emit0 !== LAT || n_acc !== WID * (CHNL - 1)) begin
            bad++;
            $display("FAIL afull_in_flight: got emits=%0d acc=%0d required emits=%0d acc=%0d",
                     n_emit - emit0, n_acc, LAT, WID * (CHNL - 1));
        end
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL afull_ready_back: got %b required 1", a_ready);
        end
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (n_acc >= NBEAT) break;
        end
        a_valid = 1'b0;
        check_pass_end("afull");
    endtask

    task automatic test_reset_mid();
        reset_model();
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (n_acc >= WID * (CHNL + 1)) break;
        end
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_busy, a_done, a_ready, a_acc_en, a_first, a_ovld, a_col, a_kern} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b required 0",
                     {a_busy, a_done, a_ready, a_acc_en, a_first, a_ovld, a_col, a_kern});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_busy, a_ready, a_acc_en} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_idle: got %b required 000", {a_busy, a_ready, a_acc_en});
        end
        a_valid = 1'b0;
        reset_model();
        mon_en = 1'b1;
        drive_pass(1'b0, 1'b0, 1'b0, 1'b1);
        check_pass_end("restart");
    endtask

    task automatic test_start_ignored();
        reset_model();
        drive_pass(1'b0, 1'b1, 1'b1, 1'b1);
        check_pass_end("start_ignored");
        @(posedge clk); #1;
        a_start = 1'b1;
        reset_model();
        @(posedge clk); #1;
        a_start = 1'b0;
        @(negedge clk);
        total++;
        if ({a_busy, a_ready} !== 2'b11) begin
            bad++;
            $display("FAIL start_after_done: got %b required 11", {a_busy, a_ready});
        end
        drive_pass(1'b0, 1'b0, 1'b0, 1'b0);
        check_pass_end("second_pass");
    endtask

    task automatic test_tiny();
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({b_ready, b_acc_en, b_busy} !== 3'b101) begin
            bad++;
            $display("FAIL tiny_accept: got %b required 101", {b_ready, b_acc_en, b_busy});
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({b_acc_en, b_first, b_ovld, b_col, b_kern, b_busy, b_done} !== 7'b1110010) begin
            bad++;
            $display("FAIL tiny_beat: got %b required 1110010",
                     {b_acc_en, b_first, b_ovld, b_col, b_kern, b_busy, b_done});
        end
        @(negedge clk);
        total++;
        if ({b_done, b_busy, b_acc_en} !== 3'b100) begin
            bad++;
            $display("FAIL tiny_done: got %b required 100", {b_done, b_busy, b_acc_en});
        end
        @(negedge clk);
        total++;
        if ({b_done, b_busy} !== 2'b00) begin
            bad++;
            $display("FAIL tiny_done_pulse: got %b required 00", {b_done, b_busy});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        a_start = 1'b0; a_valid = 1'b0; a_afull = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_afull = 1'b0;
        test_reset();
        mon_en = 1'b1;
        test_full_rate();
        test_toggle();
        test_afull();
        test_reset_mid();
        test_start_ignored();
        test_tiny();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
